// File: rtl/sbox_sched_pkg.sv
// sbox_sched_pkg: shared FSM states, direction constants and in-flight tag for the S-box scheduler.
package sbox_sched_pkg;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
  localparam logic ENC = 1'b1;
  localparam logic DEC = 1'b0;
  localparam int ID_W = 3;
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            enc;
  } tag_t;
  localparam int TAG_W = $bits(tag_t);
  function automatic logic [7:0] onehot8(input logic [ID_W-1:0] id);
    return 8'(1) << id;
  endfunction
endpackage

// File: rtl/sbox_rr_arb.sv
// sbox_rr_arb: combinational round-robin arbiter, first request at or after ptr wins.
module sbox_rr_arb
  import sbox_sched_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  logic found;
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(ptr) + k;
      idx = (idx >= N) ? idx - N : idx;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sbox_sched.sv
// sbox_sched: round-robin scheduler sharing one external S-box between N_REQ byte requesters.
module sbox_sched
  import sbox_sched_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int BURST_LEN = 4,
  parameter int SBOX_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_enc,
  input  logic [N_REQ-1:0]   req_burst,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         sbox_in,
  output logic               sbox_enc_dec,
  input  logic [7:0]         sbox_out_enc,
  input  logic [7:0]         sbox_out_dec,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [7:0]         rsp_data,
  output logic               busy
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(BURST_LEN + 1);
  state_t state, state_nx;
  logic [PW-1:0] ptr, ptr_nx, lock_id, lock_nx, hs_id;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic [N_REQ-1:0] arb_gnt;
  logic hs, dl_busy;
  tag_t iss_tag, tail;
  tag_t dl [SBOX_LAT];
  sbox_rr_arb #(.N(N_REQ), .PW(PW)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (arb_gnt)
  );
  // grants are suppressed while reset is held so no handshake can slip through
  assign req_ready = !rst_n ? '0
                   : (state == BURST) ? req_valid & N_REQ'(onehot8(ID_W'(lock_id)))
                   : arb_gnt;
  assign hs      = |(req_valid & req_ready);
  assign cnt_inc = cnt + 1'b1;
  assign tail    = dl[SBOX_LAT-1];
  always_comb begin
    hs_id = '0;
    for (int i = 0; i < N_REQ; i++)
      if (req_ready[i]) hs_id = PW'(i);
  end
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    lock_nx  = lock_id;
    cnt_nx   = cnt;
    if (hs && state == IDLE) begin
      ptr_nx = (hs_id == PW'(N_REQ - 1)) ? '0 : hs_id + 1'b1;
      if (req_burst[hs_id] && BURST_LEN > 1) begin
        state_nx = BURST;
        lock_nx  = hs_id;
        cnt_nx   = CW'(1);
      end
    end else if (hs) begin
      state_nx = (cnt_inc == CW'(BURST_LEN)) ? IDLE : BURST;
      cnt_nx   = (cnt_inc == CW'(BURST_LEN)) ? '0 : cnt_inc;
    end
  end
  always_comb begin
    dl_busy = 1'b0;
    for (int i = 0; i < SBOX_LAT; i++) dl_busy = dl_busy | dl[i].valid;
  end
  assign busy = (state != IDLE) | iss_tag.valid | dl_busy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      lock_id      <= '0;
      cnt          <= '0;
      sbox_in      <= '0;
      sbox_enc_dec <= ENC;
      iss_tag      <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      lock_id   <= lock_nx;
      cnt       <= cnt_nx;
      iss_tag   <= '{valid: hs, id: ID_W'(hs_id), enc: req_enc[hs_id]};
      rsp_valid <= tail.valid ? N_REQ'(onehot8(tail.id)) : '0;
      if (hs) begin
        sbox_in      <= req_data[8*hs_id +: 8];
        sbox_enc_dec <= req_enc[hs_id];
      end
      if (tail.valid) rsp_data <= (tail.enc == ENC) ? sbox_out_enc : sbox_out_dec;
    end
  end
  // tag delay line mirrors the register stages inside the attached S-box
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SBOX_LAT; i++) dl[i] <= '0;
    end else begin
      dl[0] <= iss_tag;
      for (int i = 1; i < SBOX_LAT; i++) dl[i] <= dl[i-1];
    end
  end
endmodule

// File: tb/tb_sbox_sched.sv
// tb_sbox_sched: directed bench for sbox_sched with a one-stage AES S-box model attached.
module tb_sbox_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0, req_enc = '0, req_burst = '0, req_ready, rsp_valid;
  logic [15:0] req_data = '0;
  logic [7:0]  sbox_in, sbox_out_enc = '0, sbox_out_dec = '0, rsp_data;
  logic        sbox_enc_dec, busy;
  int n_tests = 0, n_fail = 0, cyc = 0;
  typedef struct {int cyc; logic [1:0] id; logic [7:0] d;} rsp_t;
  rsp_t rq[$];
  int   hq[$];

  sbox_sched #(.N_REQ(2), .BURST_LEN(4), .SBOX_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_enc(req_enc), .req_burst(req_burst), .req_ready(req_ready),
    .sbox_in(sbox_in), .sbox_enc_dec(sbox_enc_dec), .sbox_out_enc(sbox_out_enc),
    .sbox_out_dec(sbox_out_dec), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  // attached S-box: one register stage, both directions computed every cycle
  always @(posedge clk) begin
    sbox_out_enc <= sbox_fwd(sbox_in);
    sbox_out_dec <= sbox_inv(sbox_in);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid != 2'b00) rq.push_back('{cyc, rsp_valid, rsp_data});
      if (|(req_valid & req_ready)) hq.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_rsp(input string tag, input logic [1:0] id, input logic [7:0] d);
    rsp_t r;
    int h;
    if (rq.size() == 0 || hq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no response expected id %0h data %0h", tag, id, d);
    end else begin
      r = rq.pop_front();
      h = hq.pop_front();
      chk({tag, "_id"}, 32'(r.id), 32'(id));
      chk({tag, "_data"}, 32'(r.d), 32'(d));
      chk({tag, "_lat"}, 32'(r.cyc - h), 32'd3);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [1:0] e, input logic [1:0] b);
    req_valid = v;
    req_data  = {d1, d0};
    req_enc   = e;
    req_burst = b;
    #1;
  endtask

  initial begin
    logic [7:0] tab [4];
    logic [1:0] gexp [4];
    tab  = '{8'h10, 8'h11, 8'h04, 8'h05};
    gexp = '{2'b01, 2'b10, 2'b01, 2'b10};
    tick(2);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rspv", 32'(rsp_valid), 0);
    chk("rst_rspd", 32'(rsp_data), 0);
    chk("rst_sbin", 32'(sbox_in), 0);
    chk("rst_encdec", 32'(sbox_enc_dec), 1);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();
    // single byte forward on req0, inverse on req1
    drive(2'b01, 8'h00, 8'h00, 2'b01, 2'b00);
    chk("s0_ready", 32'(req_ready), 32'b01);
    tick();
    drive(2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
    chk("s0_busy", 32'(busy), 1);
    chk("s0_sbin", 32'(sbox_in), 32'h00);
    tick(2);
    chk("s0_busy_done", 32'(busy), 0);
    chk("s0_rspv_now", 32'(rsp_valid), 32'b01);
    tick(2);
    pop_rsp("s0", 2'b01, 8'h63);
    drive(2'b10, 8'h00, 8'h63, 2'b00, 2'b00);
    chk("s1_ready", 32'(req_ready), 32'b10);
    tick();
    drive(2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
    chk("s1_encdec", 32'(sbox_enc_dec), 0);
    tick(4);
    pop_rsp("s1", 2'b10, 8'h00);
    // contention, also pointer wrap: last grant was req1, so req0 first
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, tab[k], tab[k], 2'b11, 2'b00);
      chk($sformatf("ct_gnt%0d", k), 32'(req_ready), 32'(gexp[k]));
      tick();
    end
    drive(2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
    tick(5);
    pop_rsp("ct0", 2'b01, 8'hCA);
    pop_rsp("ct1", 2'b10, 8'h82);
    pop_rsp("ct2", 2'b01, 8'hF2);
    pop_rsp("ct3", 2'b10, 8'h6B);
    chk("ct_extra", 32'(rq.size()), 0);
    // burst lock on req0 with req1 waiting
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 8'(k), 8'h11, 2'b11, (k == 0) ? 2'b01 : 2'b00);
      chk($sformatf("bl_gnt%0d", k), 32'(req_ready), 32'b01);
      tick();
    end
    drive(2'b11, 8'h04, 8'h11, 2'b11, 2'b00);
    chk("bl_after", 32'(req_ready), 32'b10);
    tick();
    drive(2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
    tick(5);
    pop_rsp("bl0", 2'b01, 8'h63);
    pop_rsp("bl1", 2'b01, 8'h7C);
    pop_rsp("bl2", 2'b01, 8'h77);
    pop_rsp("bl3", 2'b01, 8'h7B);
    pop_rsp("bl4", 2'b10, 8'h82);
    // bubble inside a burst keeps the lock
    drive(2'b11, 8'h10, 8'h63, 2'b01, 2'b01);
    chk("bb_gnt0", 32'(req_ready), 32'b01);
    tick();
    drive(2'b11, 8'h11, 8'h63, 2'b01, 2'b00);
    chk("bb_gnt1", 32'(req_ready), 32'b01);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(2'b10, 8'h00, 8'h63, 2'b01, 2'b00);
      chk($sformatf("bb_hold%0d", k), 32'(req_ready), 32'b00);
      tick();
      chk($sformatf("bb_busy%0d", k), 32'(busy), 1);
    end
    drive(2'b11, 8'h04, 8'h63, 2'b01, 2'b00);
    chk("bb_gnt2", 32'(req_ready), 32'b01);
    tick();
    drive(2'b11, 8'h05, 8'h63, 2'b01, 2'b00);
    chk("bb_gnt3", 32'(req_ready), 32'b01);
    tick();
    drive(2'b11, 8'h05, 8'h63, 2'b01, 2'b00);
    chk("bb_after", 32'(req_ready), 32'b10);
    tick();
    drive(2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
    tick(5);
    pop_rsp("bb0", 2'b01, 8'hCA);
    pop_rsp("bb1", 2'b01, 8'h82);
    pop_rsp("bb2", 2'b01, 8'hF2);
    pop_rsp("bb3", 2'b01, 8'h6B);
    pop_rsp("bb4", 2'b10, 8'h00);
    // reset with a burst active and two bytes in flight
    drive(2'b11, 8'h00, 8'h11, 2'b11, 2'b01);
    tick();
    drive(2'b11, 8'h01, 8'h11, 2'b11, 2'b00);
    tick();
    chk("rs_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rs_ready", 32'(req_ready), 0);
    chk("rs_rspv", 32'(rsp_valid), 0);
    chk("rs_sbin", 32'(sbox_in), 0);
    chk("rs_encdec", 32'(sbox_enc_dec), 1);
    chk("rs_busy", 32'(busy), 0);
    drive(2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("rs_no_rsp", 32'(rq.size()), 0);
    hq.delete();
    drive(2'b11, 8'h01, 8'h11, 2'b11, 2'b00);
    chk("rs_first", 32'(req_ready), 32'b01);
    tick();
    drive(2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
    tick(5);
    pop_rsp("rs0", 2'b01, 8'h7C);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
